key_event_classifier: RTL
=========================

Name: key_event_classifier

Overview:
- Sits directly downstream of the button debouncer in the dice design.
- Consumes the debounced, stable button level and classifies user gestures into single-cycle event pulses: press, single click, double click and long press.
- The dice roll/control FSM uses these events to roll, re-roll or switch modes.
- Honours the same `stop` (pause) signal as the debouncer.

Parameters:
- LONG_CYC, 1000: clk cycles the button must stay held, counted from the press, before a long press is declared.
- GAP_CYC, 300: maximum clk cycles after the first release within which a second press counts as a double click.
- CNT_W, 16: width of the shared duration counter. Must satisfy 2^CNT_W > max(LONG_CYC, GAP_CYC). An elaboration-time check fails if it does not.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- stop  in  1  pause; synchronous clear, highest priority after reset
- btn_db  in  1  debounced button level (1 = pressed), already synchronous to clk
- press_pulse  out  1  one-cycle pulse on every press
- single_click  out  1  one-cycle pulse when a short press is not followed by a second press within GAP_CYC
- double_click  out  1  one-cycle pulse on the second press of a double click
- long_press  out  1  one-cycle pulse when the hold reaches LONG_CYC
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: every output is 0, state = IDLE, cnt = 0, btn_d = 0.
- Edge detection: btn_d is btn_db delayed one cycle.
  - rise = btn_db & ~btn_d
  - fall = ~btn_db & btn_d
- Pulse timing: a pulse caused by an event sampled at edge k is high from edge k until edge k+1. Every pulse lasts exactly one cycle.
- press_pulse fires on every rise while stop = 0, in any state.
- stop = 1:
  - Forces state = IDLE, cnt = 0 and all pulses to 0. busy drops at the same edge.
  - btn_d keeps tracking btn_db, so a button still held when stop releases produces no rise.
- FSM:
  - IDLE:
    - rise → PRESS1, cnt = 0.
  - PRESS1:
    - While held, cnt increments.
    - If cnt = LONG_CYC-1 and the button is still held → LONG, long_press pulse.
    - fall (before long) → GAP, cnt = 0.
  - GAP:
    - cnt increments.
    - rise → PRESS2, double_click pulse.
    - If cnt = GAP_CYC-1 with no rise → IDLE, single_click pulse.
  - PRESS2:
    - fall → IDLE. No long-press detection in this state.
  - LONG:
    - fall → IDLE. No further events are emitted.
- Boundary cases:
  - rise and GAP timeout in the same cycle: rise wins, so double_click fires and single_click does not.
  - fall in the same cycle that PRESS1 reaches LONG_CYC-1: fall wins, giving GAP with no long_press.
  - The counter never wraps; all terminal compares are equality on values below 2^CNT_W.
  - At most one of single_click, double_click or long_press is high in any cycle.
  - press_pulse may coincide with double_click.
- Reset asserted mid-gesture: immediate return to IDLE with outputs at 0. A button held through reset release generates no press_pulse.

Decomposition:
- Shared package dice_pkg holds:
  - the kc_state_t enum {IDLE, PRESS1, GAP, PRESS2, LONG}
  - default constants KC_LONG_CYC and KC_GAP_CYC
  - the CNT_W default
- One natural sub-module, key_edge_det: clk, rst_n, d → rise, fall, d_q. It is reused wherever a level needs edge pulses.
- The FSM, counter and output registers stay in key_event_classifier.

Test Plan:
All scenarios use LONG_CYC = 10 and GAP_CYC = 5.
- Reset check: hold rst_n = 0, then release; drive btn_db = 1 from cycle 0 → no output pulses; busy = 0 and state = IDLE throughout.
- Single click: btn_db high for 3 cycles, then low for 8 → press_pulse for 1 cycle after the rise; single_click exactly once, 5 cycles after the fall; busy is low afterwards.
- Double click: high 3, low 2, high 3, low → two press_pulse; double_click coincides with the second press_pulse; no single_click and no long_press.
- Long press: hold high for 15 cycles → press_pulse, then long_press 10 cycles after the press (count from the first held sample); nothing on release.
- Boundary cases:
  - Second rise on the exact GAP timeout cycle → double_click only.
  - Fall on the cycle where cnt = 9 → no long_press; single_click follows.
- Stop: assert stop during GAP with a second rise pending → no double_click or single_click and busy drops; release stop with btn_db already high → no press_pulse.

Source files
------------

// File: rtl/dice_pkg.sv
// Types and default constants shared by the dice design's button-handling blocks.
package dice_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        GAP    = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } kc_state_t;

    localparam int KC_LONG_CYC = 1000;
    localparam int KC_GAP_CYC  = 300;
    localparam int KC_CNT_W    = 16;

endpackage

// File: rtl/key_edge_det.sv
// Registers a synchronous level and produces single-cycle rise/fall indications.
module key_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise,
    output logic fall,
    output logic d_q
);

    logic r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d <= 1'b0;
        end else begin
            r_d <= d;
        end
    end

    assign rise = d & ~r_d;
    assign fall = ~d & r_d;
    assign d_q  = r_d;

endmodule

// File: rtl/key_event_classifier.sv
// Turns the debounced button level into press / single / double / long-press event pulses.
//
//   state  | meaning
//   IDLE   | no gesture in progress
//   PRESS1 | first press held, counting towards long press
//   GAP    | first press released, waiting for a second press
//   PRESS2 | second press of a double click held
//   LONG   | long press declared, waiting for release
module key_event_classifier
    import dice_pkg::*;
#(
    parameter int LONG_CYC = KC_LONG_CYC,
    parameter int GAP_CYC  = KC_GAP_CYC,
    parameter int CNT_W    = KC_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stop,
    input  logic btn_db,
    output logic press_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    if (((64'd1 << CNT_W) <= 64'(LONG_CYC)) || ((64'd1 << CNT_W) <= 64'(GAP_CYC))) begin : g_cnt_w_chk
        $error("key_event_classifier: CNT_W too narrow for LONG_CYC/GAP_CYC");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);

    logic w_rise;
    logic w_fall;
    logic w_btn_d;
    logic w_held;

    kc_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_live;
    logic             r_press;
    logic             r_single;
    logic             r_double;
    logic             r_long;
    logic             r_busy;

    key_edge_det u_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_db),
        .rise  (w_rise),
        .fall  (w_fall),
        .d_q   (w_btn_d)
    );

    assign w_held = btn_db & w_btn_d;

    // r_live masks the first edge after reset so a button held through reset
    // release only loads the edge detector instead of looking like a new press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_live   <= 1'b0;
            r_press  <= 1'b0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_press  <= 1'b0;
            r_single <= 1'b0;
            r_double <= 1'b0;
            r_long   <= 1'b0;
            if (!r_live) begin
                r_live <= 1'b1;
            end else if (stop) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_busy  <= 1'b0;
            end else begin
                r_press <= w_rise;
                case (r_state)
                    IDLE: begin
                        if (w_rise) begin
                            r_state <= PRESS1;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                        end
                    end
                    PRESS1: begin
                        if (w_fall) begin
                            r_state <= GAP;
                            r_cnt   <= '0;
                        end else if (w_held && (r_cnt == LONG_LAST)) begin
                            r_state <= LONG;
                            r_long  <= 1'b1;
                        end else if (w_held) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    GAP: begin
                        if (w_rise) begin
                            r_state  <= PRESS2;
                            r_cnt    <= '0;
                            r_double <= 1'b1;
                        end else if (r_cnt == GAP_LAST) begin
                            r_state  <= IDLE;
                            r_cnt    <= '0;
                            r_single <= 1'b1;
                            r_busy   <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    PRESS2, LONG: begin
                        if (w_fall) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign press_pulse  = r_press;
    assign single_click = r_single;
    assign double_click = r_double;
    assign long_press   = r_long;
    assign busy         = r_busy;

endmodule
